// File: rtl/acc_encoder.sv
// acc_encoder: packs a 32-bit two's-complement accumulator, received as two
// half-words, into an 8-bit {sign, exp[3:0], man[2:0]} minifloat (value = man << exp).
module acc_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_word,
    input  logic        in_hl,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        ovf,
    output logic        proto_err
);
    typedef enum logic [1:0] {WAIT_HI, WAIT_LO, NORM, HOLD} state_t;

    state_t      state_q, state_d;
    logic [15:0] hi_q, hi_d;
    logic        sign_q, sign_d;
    logic [31:0] mag_q, mag_d;
    logic [4:0]  exp_q, exp_d;
    logic        rnd_q, rnd_d;
    logic [7:0]  byte_q, byte_d;
    logic        ovf_q, ovf_d;
    logic        perr_q, perr_d;
    logic        alive_q;

    logic [31:0] acc;
    logic [3:0]  m;
    logic [4:0]  fexp;
    logic        sat, xfer;

    always_comb begin
        acc     = {hi_q, in_word};
        xfer    = in_valid & in_ready;
        m       = {1'b0, mag_q[2:0]} + {3'd0, rnd_q};
        // a rounding carry (m = 8) renormalises to 4 << (exp + 1)
        fexp    = exp_q + {4'd0, m[3]};
        sat     = exp_q[4] | fexp[4];
        state_d = state_q;
        hi_d    = hi_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        rnd_d   = rnd_q;
        byte_d  = byte_q;
        ovf_d   = ovf_q;
        perr_d  = 1'b0;
        unique case (state_q)
            WAIT_HI: if (xfer) begin
                hi_d    = in_hl ? in_word : hi_q;
                perr_d  = ~in_hl;
                state_d = in_hl ? WAIT_LO : WAIT_HI;
            end
            WAIT_LO: if (xfer) begin
                if (in_hl) begin
                    hi_d   = in_word;
                    perr_d = 1'b1;
                end else begin
                    sign_d  = acc[31];
                    mag_d   = acc[31] ? ~acc + 32'd1 : acc;
                    exp_d   = 5'd0;
                    rnd_d   = 1'b0;
                    state_d = NORM;
                end
            end
            NORM: if ((|mag_q[31:3]) && !exp_q[4]) begin
                mag_d = mag_q >> 1;
                rnd_d = mag_q[0];
                exp_d = exp_q + 5'd1;
            end else begin
                byte_d  = sat ? {sign_q, 7'h7F} :
                          {sign_q & (|mag_q), m[3] ? {fexp[3:0], 3'd4} : {exp_q[3:0], m[2:0]}};
                ovf_d   = sat;
                state_d = HOLD;
            end
            HOLD: if (out_ready) begin
                ovf_d   = 1'b0;
                state_d = WAIT_HI;
            end
            default: state_d = WAIT_HI;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WAIT_HI;
            hi_q    <= 16'd0;
            sign_q  <= 1'b0;
            mag_q   <= 32'd0;
            exp_q   <= 5'd0;
            rnd_q   <= 1'b0;
            byte_q  <= 8'h00;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            rnd_q   <= rnd_d;
            byte_q  <= byte_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
            alive_q <= 1'b1;
        end
    end

    assign in_ready  = alive_q & (state_q == WAIT_HI || state_q == WAIT_LO);
    assign out_valid = state_q == HOLD;
    assign out_byte  = byte_q;
    assign ovf       = ovf_q & (state_q == HOLD);
    assign proto_err = perr_q;
endmodule

// File: doc/acc_encoder.md
ACC_ENCODER -- requirements
Module: acc_encoder

Interface
REQ-001 The block SHALL have no parameters; formats are fixed: 32-bit two's-complement accumulator in, 8-bit minifloat {sign[7], exp[6:3], man[2:0]} out, value = man << exp.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-004 in_word  input  16  one accumulator half-word.
REQ-005 in_hl  input  1  1 = in_word is bits [31:16], 0 = bits [15:0].
REQ-006 in_valid  input  1  in_word/in_hl valid.
REQ-007 in_ready  output  1  block can accept a half-word.
REQ-008 out_byte  output  8  encoded minifloat.
REQ-009 out_valid  output  1  out_byte/ovf valid.
REQ-010 out_ready  input  1  consumer accepts out_byte.
REQ-011 ovf  output  1  result saturated; valid with out_valid.
REQ-012 proto_err  output  1  one-cycle pulse on a half-word received out of order.

Function
REQ-013 Half-word transfer SHALL occur on a rising edge with in_valid & in_ready; output transfer on out_valid & out_ready.
REQ-014 The FSM SHALL have states WAIT_HI, WAIT_LO, NORM, HOLD; in_ready = 1 only in WAIT_HI and WAIT_LO.
REQ-015 WAIT_HI: transfer with in_hl=1 latches high half, goes to WAIT_LO; transfer with in_hl=0 is discarded, proto_err pulses, state unchanged.
REQ-016 WAIT_LO: transfer with in_hl=0 latches low half, loads sign = bit31, mag = |value| as 32-bit unsigned (0x80000000 -> 2^31), exp = 0, rnd = 0, goes to NORM.
REQ-017 WAIT_LO: transfer with in_hl=1 replaces the high half, proto_err pulses, state stays WAIT_LO.
REQ-018 NORM, each cycle, if mag > 7 and exp < 16: mag <= mag >> 1, rnd <= shifted-out bit, exp <= exp + 1.
REQ-019 NORM, otherwise: m = mag + rnd (round half away from zero on magnitude); if m = 8 then m = 4, exp = exp + 1; register the result, go to HOLD.
REQ-020 If final exp > 15 or exp reached 16: out_byte = {sign, 4'hF, 3'h7}, ovf = 1; else out_byte = {sign, exp[3:0], m[2:0]}, ovf = 0.
REQ-021 A zero magnitude SHALL encode as 8'h00 (no negative zero), ovf = 0.
REQ-022 Latency: out_valid SHALL rise k+1 edges after the low-half transfer edge, k = number of NORM shifts (0..16); worst case 17.
REQ-023 HOLD: out_valid = 1; out_byte and ovf stable until transfer; on transfer go to WAIT_HI; in_ready = 0 throughout HOLD.
REQ-024 out_valid, ovf, proto_err SHALL be 0 in every state other than as stated above.
REQ-025 in_word/in_hl SHALL be ignored when in_valid = 0.

Reset
REQ-026 While reset = 0: state = WAIT_HI, out_byte = 8'h00, out_valid = 0, ovf = 0, proto_err = 0, in_ready = 0; in_ready = 1 from the first edge after reset deasserts.
REQ-027 Reset asserted in any state, including mid-NORM or HOLD, SHALL abort the operation; no partial result is later emitted.

Verification
REQ-028 Send 0x0000 (hl=1), 0x0064 (hl=0) [value 100] -> k = 4, out_valid 5 edges later, out_byte = 0x26, ovf = 0.
REQ-029 Send 0x0000, 0x000F [15] -> rounding carry, out_byte = 0x14; send 0xFFFF, 0xFFFD [-3] -> out_byte = 0x83, out_valid 1 edge after low accept.
REQ-030 Boundaries: 0x00038000 -> 0x7F ovf = 0; 0x00037FFF -> 0x7F ovf = 0; 0x0003C000 -> 0x7F ovf = 1; 0x7FFFFFFF -> 0x7F ovf = 1; 0x80000000 -> 0xFF ovf = 1; 0x00000000 and 0xFFFFFFFF -> 0x00 and 0x81.
REQ-031 Protocol: low half first -> proto_err pulse, no state change; two high halves -> proto_err pulse, second high used; out_ready held 0 for 10 cycles -> out_byte stable, in_ready = 0 throughout.
REQ-032 Reset pulse during NORM of 0x7FFFFFFF -> outputs at reset values, no out_valid until a new full transfer pair completes.
